// File: rtl/pwm_frame_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_frame_sequencer
//
// Produces a repeating PWM frame for the motor ESC outputs. One shared slot
// counter times each channel in turn: a pulse, a fixed low gap, then the next
// channel. After the last gap the block waits for the frame boundary. Widths
// are double-buffered: software writes a pending set, and the active set is
// refreshed only when a new frame starts.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   enable       run request, acted on from IDLE and at each frame boundary
//   width_in     packed widths, channel c at [c*N +: N]
//   width_load   captures width_in into the pending registers
//   pwm_out      registered PWM outputs, at most one high
//   active_ch    channel whose pulse/gap slot is in progress, else 0
//   frame_start  one-cycle pulse on frame offset 0
//   overrun      one-cycle pulse with frame_start when the previous frame
//                ended before its schedule finished
//   busy         high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module pwm_frame_sequencer #(
    parameter int N            = 16,
    parameter int CHANNELS     = 4,
    parameter int FRAME_CYCLES = 20000,
    parameter int GAP_CYCLES   = 100,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CHANNELS*N-1:0] width_in,
    input  logic                  width_load,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic [CH_W-1:0]       active_ch,
    output logic                  frame_start,
    output logic                  overrun,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT} state_t;

    localparam logic [N-1:0]    FRAME_LAST = N'(FRAME_CYCLES - 1);
    localparam logic [N-1:0]    GAP_LAST   = N'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(CHANNELS - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    frame_cnt_q, frame_cnt_d;
    logic [N-1:0]    slot_cnt_q, slot_cnt_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            ovr_pend_q, ovr_pend_d;
    logic            load_active;

    logic [N-1:0]    pending_q [CHANNELS];
    logic [N-1:0]    active_q  [CHANNELS];

    logic [CHANNELS-1:0] pwm_d;
    logic [CH_W-1:0]     active_ch_d;
    logic                frame_start_d, overrun_d, busy_d;

    logic [N-1:0] cur_w;
    logic [N:0]   slot_next;
    logic         pulse_done, gap_done, frame_end;

    assign cur_w      = active_q[ch_q];
    assign slot_next  = {1'b0, slot_cnt_q} + (N+1)'(1);
    // A zero-width slot still occupies one cycle, so "done" is reached on
    // the first cycle when cur_w is 0.
    assign pulse_done = slot_next >= {1'b0, cur_w};
    assign gap_done   = slot_cnt_q == GAP_LAST;
    assign frame_end  = (state_q != IDLE) && (frame_cnt_q == FRAME_LAST);

    // State and counter registers, width buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            slot_cnt_q  <= '0;
            ch_q        <= '0;
            ovr_pend_q  <= 1'b0;
            // NOTE: the width arrays are reset explicitly so the first frame
            // after reset runs with defined zero widths instead of whatever
            // the flops powered up with.
            for (int c = 0; c < CHANNELS; c++) begin
                pending_q[c] <= '0;
                active_q[c]  <= '0;
            end
            pwm_out     <= '0;
            active_ch   <= '0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; active_q <= pending_q relies on that to
            // take the old pending set when width_load lands on the same edge.
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            ch_q        <= ch_d;
            ovr_pend_q  <= ovr_pend_d;
            if (load_active) begin
                active_q <= pending_q;
            end
            if (width_load) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    pending_q[c] <= width_in[c*N +: N];
                end
            end
            pwm_out     <= pwm_d;
            active_ch   <= active_ch_d;
            frame_start <= frame_start_d;
            overrun     <= overrun_d;
            busy        <= busy_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q + N'(1);
        slot_cnt_d  = slot_cnt_q + N'(1);
        ch_d        = ch_q;
        ovr_pend_d  = ovr_pend_q;
        load_active = 1'b0;

        unique case (state_q)
            IDLE: begin
                frame_cnt_d = '0;
                slot_cnt_d  = '0;
                if (enable) begin
                    state_d     = PULSE;
                    ch_d        = '0;
                    ovr_pend_d  = 1'b0;
                    load_active = 1'b1;
                end
            end
            PULSE: begin
                if (pulse_done) begin
                    state_d    = GAP;
                    slot_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_done) begin
                    slot_cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        state_d = WAIT;
                    end else begin
                        state_d = PULSE;
                        ch_d    = ch_q + CH_W'(1);
                    end
                end
            end
            WAIT: begin
                slot_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The frame boundary overrides whatever slot is in progress; a
        // boundary hit before WAIT truncates the schedule.
        if (frame_end) begin
            frame_cnt_d = '0;
            slot_cnt_d  = '0;
            ch_d        = '0;
            if (enable) begin
                state_d     = PULSE;
                load_active = 1'b1;
                ovr_pend_d  = (state_q == PULSE) || (state_q == GAP);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Output decode, registered above.
    always_comb begin
        pwm_d = '0;
        if (state_q == PULSE && cur_w != '0) begin
            pwm_d[ch_q] = 1'b1;
        end
        active_ch_d   = (state_q == PULSE || state_q == GAP) ? ch_q : '0;
        busy_d        = state_q != IDLE;
        frame_start_d = busy_d && (frame_cnt_q == '0);
        overrun_d     = frame_start_d && ovr_pend_q;
    end

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_frame_sequencer
//
// Drives directed scenarios (reset, nominal frame, zero width, mid-frame and
// coincident width loads, overrun, graceful stop) followed by randomized
// traffic, and compares every output on every cycle against a reference model
// that derives each cycle's outputs from the frame offset and the slot start
// arithmetic S(c) = sum over k<c of (max(w_k,1) + GAP).
// -----------------------------------------------------------------------------
module tb_pwm_frame_sequencer;

    localparam int N     = 16;
    localparam int CH    = 4;
    localparam int FRAME = 200;
    localparam int GAP   = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic            width_load = 1'b0;
    logic [CH*N-1:0] width_in = '0;
    logic [CH-1:0]   pwm_out;
    logic [1:0]      active_ch;
    logic            frame_start;
    logic            overrun;
    logic            busy;

    always #5 clk = ~clk;

    pwm_frame_sequencer #(
        .N(N), .CHANNELS(CH), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .width_in(width_in), .width_load(width_load),
        .pwm_out(pwm_out), .active_ch(active_ch),
        .frame_start(frame_start), .overrun(overrun), .busy(busy)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cycle   = 0;

    // Reference model state: frame offset (-1 = idle), widths in use,
    // pending widths, and whether the frame now running was preceded by
    // a truncated one.
    int pos = -1;
    int shown_pos = -1;
    int fw[CH];
    int pend[CH];
    bit ovr = 1'b0;

    logic [CH-1:0] e_pwm;
    int            e_ch;
    bit            e_fs, e_ov, e_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    endtask

    function automatic int schedule_len();
        int t = 0;
        for (int c = 0; c < CH; c++) t += ((fw[c] > 0) ? fw[c] : 1) + GAP;
        return t;
    endfunction

    // Called at each rising edge: outputs after this edge reflect the
    // position held before it; then the position advances.
    task automatic model_edge();
        int s;
        int len;
        if (!reset) begin
            pos = -1; shown_pos = -1; ovr = 1'b0;
            for (int c = 0; c < CH; c++) begin fw[c] = 0; pend[c] = 0; end
            e_pwm = '0; e_ch = 0; e_fs = 0; e_ov = 0; e_busy = 0;
            return;
        end
        shown_pos = pos;
        e_pwm = '0; e_ch = 0; e_fs = 0; e_ov = 0;
        e_busy = pos >= 0;
        if (pos >= 0) begin
            e_fs = pos == 0;
            e_ov = (pos == 0) && ovr;
            s = 0;
            for (int c = 0; c < CH; c++) begin
                len = (fw[c] > 0) ? fw[c] : 1;
                if (pos >= s && pos < s + len) begin
                    e_ch = c;
                    if (fw[c] > 0) e_pwm[c] = 1'b1;
                end else if (pos >= s + len && pos < s + len + GAP) begin
                    e_ch = c;
                end
                s += len + GAP;
            end
        end
        if (pos < 0) begin
            if (enable) begin pos = 0; fw = pend; ovr = 1'b0; end
        end else if (pos == FRAME - 1) begin
            if (enable) begin
                ovr = schedule_len() >= FRAME;
                pos = 0;
                fw  = pend;
            end else begin
                pos = -1;
            end
        end else begin
            pos++;
        end
        if (width_load) for (int c = 0; c < CH; c++) pend[c] = int'(width_in[c*N +: N]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cycle++;
        check("pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("active_ch", 32'(active_ch), 32'(e_ch));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("overrun", 32'(overrun), 32'(e_ov));
        check("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Advance until the outputs show frame offset p, with a bounded budget.
    task automatic run_to(input int p);
        int k = 0;
        do begin
            tick();
            k++;
        end while (shown_pos != p && k < 2000);
        check("run_to_offset", 32'(shown_pos), 32'(p));
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        width_in = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    task automatic load_once(input int a, input int b, input int c, input int d);
        set_w(a, b, c, d);
        width_load = 1'b1;
        tick();
        width_load = 1'b0;
    endtask

    initial begin
        // Reset held with enable and width_load asserted.
        reset = 1'b0; enable = 1'b1; width_load = 1'b1;
        set_w(int'($urandom_range(1, 99)), 33, 44, 55);
        run(6);
        reset = 1'b1; width_load = 1'b0;

        // First frame runs with zero widths; load nominal mid-frame.
        run_to(50);
        load_once(20, 30, 40, 50);
        run_to(0);
        run_to(0);

        // Mid-frame update takes effect on the next frame only.
        run_to(50);
        load_once(60, 10, 10, 10);
        run_to(0);

        // Load coincident with frame_start is deferred one more frame.
        load_once(20, 0, 40, 50);
        run_to(0);
        run_to(0);

        // Overrun frames.
        run_to(50);
        load_once(100, 100, 100, 100);
        run_to(0);
        run_to(0);
        run_to(0);

        // Graceful stop from a nominal frame.
        run_to(50);
        load_once(20, 30, 40, 50);
        run_to(0);
        run_to(60);
        enable = 1'b0;
        run_to(FRAME - 1);
        run(20);
        check("stopped_busy", 32'(busy), 32'(0));

        // Stop cancelled by re-asserting enable before the boundary.
        enable = 1'b1;
        run_to(60);
        enable = 1'b0;
        run_to(150);
        enable = 1'b1;
        run_to(0);
        run_to(0);

        // Randomized traffic, including occasional mid-frame resets.
        repeat (4000) begin
            width_load = ($urandom_range(0, 19) == 0);
            if (width_load)
                set_w(int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
                      int'($urandom_range(0, 70)), int'($urandom_range(0, 70)));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            reset = ($urandom_range(0, 699) != 0);
            tick();
        end
        reset = 1'b1; width_load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
